// File: rtl/spi_image_receiver.sv
// SPI image receiver: collects a framed image of 4-bit pixels over SPI,
// unpacks it into a pixel buffer, then returns the classifier result to the
// SPI master on a following 8-bit read.
module spi_image_receiver #(
  parameter int         NUM_BYTES = 72,
  parameter logic [7:0] START_CMD = 8'h00,
  parameter logic [7:0] END_CMD   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  output logic [7:0] pixel_waddr,
  output logic [3:0] pixel_wdata,
  output logic       pixel_we,
  output logic       image_ready,
  input  logic [7:0] result,
  input  logic       result_valid,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RECV        = 3'd1,
    WAIT_END    = 3'd2,
    WAIT_RESULT = 3'd3,
    SEND        = 3'd4
  } state_t;

  // [0],[1] are the synchronizer flops, [2] is the history bit for edge detect
  logic [2:0] sck_sync_q, ss_sync_q;
  logic [1:0] mosi_sync_q;

  logic       sck_rise, ss_fall, ss_rise, ss_low;

  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       byte_done_q;

  state_t     state_q, state_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] txsh_q, txsh_d;
  logic       sent_q, sent_d;
  logic       hi_pend_q, hi_pend_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       we_q, we_d;
  logic [7:0] waddr_q, waddr_d;
  logic [3:0] wdata_q, wdata_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;

  assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
  assign ss_fall  = ~ss_sync_q[1]  &  ss_sync_q[2];
  assign ss_rise  =  ss_sync_q[1]  & ~ss_sync_q[2];
  assign ss_low   = ~ss_sync_q[1];

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b11;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], SCK};
      ss_sync_q   <= {ss_sync_q[1:0], SS};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  // Byte deserializer: LSB first, a short byte is dropped when SS rises
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= sck_rise & ss_low & (bit_cnt_q == 3'd7);
      if (ss_rise) begin
        bit_cnt_q <= 3'd0;
        shift_q   <= 8'h00;
      end else if (sck_rise && ss_low) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= {mosi_sync_q[1], shift_q[7:1]};
      end
    end
  end

  // Protocol state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= 7'd0;
      tx_q       <= 8'h00;
      txsh_q     <= 8'h00;
      sent_q     <= 1'b0;
      hi_pend_q  <= 1'b0;
      hi_nib_q   <= 4'h0;
      we_q       <= 1'b0;
      waddr_q    <= 8'h00;
      wdata_q    <= 4'h0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
      txsh_q     <= txsh_d;
      sent_q     <= sent_d;
      hi_pend_q  <= hi_pend_d;
      hi_nib_q   <= hi_nib_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Frame FSM, pixel unpacking and result transmit path
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    txsh_d     = txsh_q;
    sent_d     = sent_q;
    hi_pend_d  = 1'b0;
    hi_nib_d   = hi_nib_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;

    // second half of an unpack: high nibble goes to the odd address
    if (hi_pend_q) begin
      we_d    = 1'b1;
      waddr_d = waddr_q + 8'd1;
      wdata_d = hi_nib_q;
    end

    case (state_q)
      IDLE: begin
        if (byte_done_q && shift_q == START_CMD) begin
          state_d    = RECV;
          byte_cnt_d = 7'd0;
        end
      end
      RECV: begin
        if (byte_done_q) begin
          we_d      = 1'b1;
          waddr_d   = {byte_cnt_q, 1'b0};
          wdata_d   = shift_q[3:0];
          hi_pend_d = 1'b1;
          hi_nib_d  = shift_q[7:4];
          if (byte_cnt_q == 7'(NUM_BYTES - 1)) state_d = WAIT_END;
          else                                 byte_cnt_d = byte_cnt_q + 7'd1;
        end
      end
      WAIT_END: begin
        if (byte_done_q) begin
          if (shift_q == END_CMD) begin
            ready_d = 1'b1;
            state_d = WAIT_RESULT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_RESULT: begin
        if (result_valid) begin
          tx_d    = result;
          txsh_d  = result;
          sent_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        // each SS-low window restarts from tx[0]; only a full 8-bit window ends the read
        if (ss_fall) begin
          txsh_d = tx_q;
          sent_d = 1'b0;
        end else if (sck_rise && ss_low) begin
          txsh_d = {1'b1, txsh_q[7:1]};
        end
        if (byte_done_q) sent_d = 1'b1;
        if (ss_rise) begin
          sent_d = 1'b0;
          txsh_d = tx_q;
          if (sent_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO        = (rst || state_q != SEND || ss_sync_q[1]) ? 1'b1 : txsh_q[0];
  assign pixel_we    = we_q;
  assign pixel_waddr = waddr_q;
  assign pixel_wdata = wdata_q;
  assign image_ready = ready_q;
  assign frame_err   = err_q;

endmodule
